// File: rtl/exec_done_monitor.sv
// rtl/exec_done_monitor.sv - end-of-run detector for a main CPU plus PIM core pair
//
// Purpose: watches both cores for an exit ECALL (fetched ECALL_WORD with a7 == EXIT_A7),
// latches a sticky done flag and the core's cycle count at its first exit, and once both
// cores are done waits for the PIM bus to go idle and stay idle for DRAIN_CYCLES cycles
// before issuing a single stop_req pulse. wall_cycles counts the run length.
//
// Ports:
//   clk, reset                        clock, synchronous active-high reset
//   main_fetch_valid/rdata/a7/cycles  main core fetch data, x17 and cycle counter
//   pim_fetch_valid/rdata/a7/cycles   same for the PIM core
//   pim_sel                           PIM bus transaction in flight
//   clear                             synchronous soft clear, same effect as reset
//   main_done, pim_done               sticky per-core exit flags
//   main_cycles_q, pim_cycles_q       cycle count captured at each core's first exit
//   state_o                           RUN=0, WAIT_SEL=1, DRAIN=2, STOPPED=3
//   stop_req                          one-cycle end-of-run pulse
//   wall_cycles                       cycles since reset/clear, frozen once stopped

module exec_done_monitor #(
   parameter logic [31:0] ECALL_WORD   = 32'h00000073,
   parameter logic [31:0] EXIT_A7      = 32'd1,
   parameter int unsigned DRAIN_CYCLES = 3
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        main_fetch_valid,
   input  logic [31:0] main_rdata,
   input  logic [31:0] main_a7,
   input  logic [63:0] main_cycles,
   input  logic        pim_fetch_valid,
   input  logic [31:0] pim_rdata,
   input  logic [31:0] pim_a7,
   input  logic [63:0] pim_cycles,
   input  logic        pim_sel,
   input  logic        clear,
   output logic        main_done,
   output logic        pim_done,
   output logic [63:0] main_cycles_q,
   output logic [63:0] pim_cycles_q,
   output logic [1:0]  state_o,
   output logic        stop_req,
   output logic [63:0] wall_cycles
);

   typedef enum logic [1:0] {
      ST_RUN      = 2'd0,
      ST_WAIT_SEL = 2'd1,
      ST_DRAIN    = 2'd2,
      ST_STOPPED  = 2'd3
   } state_t;

   localparam logic [7:0] DRAIN_LOAD = 8'(DRAIN_CYCLES - 1);

   state_t      r_state;
   state_t      w_next_state;
   logic [7:0]  r_drain_cnt;
   logic [7:0]  w_next_cnt;
   logic        w_stop;
   logic        w_restart;
   logic        w_both_done;
   logic        w_main_exit;
   logic        w_pim_exit;
   logic        r_main_done;
   logic        r_pim_done;
   logic [63:0] r_main_cycles_q;
   logic [63:0] r_pim_cycles_q;
   logic [63:0] r_wall_cycles;

   // reset and clear are interchangeable; anything seen in that cycle is discarded
   assign w_restart   = reset | clear;
   assign w_both_done = r_main_done & r_pim_done;

   // exits are ignored once the run has stopped
   assign w_main_exit = main_fetch_valid && (main_rdata == ECALL_WORD) &&
                        (main_a7 == EXIT_A7) && (r_state != ST_STOPPED);
   assign w_pim_exit  = pim_fetch_valid && (pim_rdata == ECALL_WORD) &&
                        (pim_a7 == EXIT_A7) && (r_state != ST_STOPPED);

   always_ff @(posedge clk) begin
      if (w_restart) begin
         r_state     <= ST_RUN;
         r_drain_cnt <= 8'd0;
      end else begin
         r_state     <= w_next_state;
         r_drain_cnt <= w_next_cnt;
      end
   end

   always_comb begin
      w_next_state = r_state;
      w_next_cnt   = r_drain_cnt;
      w_stop       = 1'b0;
      case (r_state)
         ST_RUN: begin
            if (w_both_done) begin
               if (pim_sel) begin
                  w_next_state = ST_WAIT_SEL;
               end else begin
                  w_next_state = ST_DRAIN;
                  w_next_cnt   = DRAIN_LOAD;
               end
            end
         end
         ST_WAIT_SEL: begin
            if (!pim_sel) begin
               w_next_state = ST_DRAIN;
               w_next_cnt   = DRAIN_LOAD;
            end
         end
         ST_DRAIN: begin
            // renewed bus activity restarts the whole idle window
            if (pim_sel) begin
               w_next_state = ST_WAIT_SEL;
            end else if (r_drain_cnt == 8'd0) begin
               w_next_state = ST_STOPPED;
               w_stop       = 1'b1;
            end else begin
               w_next_cnt = r_drain_cnt - 8'd1;
            end
         end
         default: begin
            w_next_state = ST_STOPPED;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (w_restart) begin
         r_main_done     <= 1'b0;
         r_pim_done      <= 1'b0;
         r_main_cycles_q <= 64'd0;
         r_pim_cycles_q  <= 64'd0;
         r_wall_cycles   <= 64'd0;
      end else begin
         // only the first exit per core captures a cycle count
         if (w_main_exit && !r_main_done) begin
            r_main_done     <= 1'b1;
            r_main_cycles_q <= main_cycles;
         end
         if (w_pim_exit && !r_pim_done) begin
            r_pim_done     <= 1'b1;
            r_pim_cycles_q <= pim_cycles;
         end
         if ((r_state != ST_STOPPED) && (r_wall_cycles != '1)) begin
            r_wall_cycles <= r_wall_cycles + 64'd1;
         end
      end
   end

   assign main_done     = r_main_done;
   assign pim_done      = r_pim_done;
   assign main_cycles_q = r_main_cycles_q;
   assign pim_cycles_q  = r_pim_cycles_q;
   assign state_o       = r_state;
   // suppressed when the transition itself is being overridden by reset/clear
   assign stop_req      = w_stop & ~w_restart;
   assign wall_cycles   = r_wall_cycles;

endmodule

// File: tb/tb_exec_done_monitor.sv
// tb/tb_exec_done_monitor.sv - self-checking bench for exec_done_monitor

module tb_exec_done_monitor;

   localparam logic [31:0] ECALL = 32'h00000073;
   localparam logic [31:0] EXIT  = 32'd1;
   localparam int          DRAIN = 3;

   logic        clk;
   logic        reset;
   logic        main_fetch_valid;
   logic [31:0] main_rdata;
   logic [31:0] main_a7;
   logic [63:0] main_cycles;
   logic        pim_fetch_valid;
   logic [31:0] pim_rdata;
   logic [31:0] pim_a7;
   logic [63:0] pim_cycles;
   logic        pim_sel;
   logic        clear;
   logic        main_done;
   logic        pim_done;
   logic [63:0] main_cycles_q;
   logic [63:0] pim_cycles_q;
   logic [1:0]  state_o;
   logic        stop_req;
   logic [63:0] wall_cycles;

   exec_done_monitor #(
      .ECALL_WORD   (ECALL),
      .EXIT_A7      (EXIT),
      .DRAIN_CYCLES (DRAIN)
   ) dut (
      .clk              (clk),
      .reset            (reset),
      .main_fetch_valid (main_fetch_valid),
      .main_rdata       (main_rdata),
      .main_a7          (main_a7),
      .main_cycles      (main_cycles),
      .pim_fetch_valid  (pim_fetch_valid),
      .pim_rdata        (pim_rdata),
      .pim_a7           (pim_a7),
      .pim_cycles       (pim_cycles),
      .pim_sel          (pim_sel),
      .clear            (clear),
      .main_done        (main_done),
      .pim_done         (pim_done),
      .main_cycles_q    (main_cycles_q),
      .pim_cycles_q     (pim_cycles_q),
      .state_o          (state_o),
      .stop_req         (stop_req),
      .wall_cycles      (wall_cycles)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;
   int cyc_no   = 0;
   int n_stop   = 0;
   int n_wait   = 0;
   int stop_cyc = -1;
   int e_cyc;
   int f_cyc;

   // Reference model: stop is due once both cores are done and pim_sel has been
   // low for DRAIN+1 consecutive cycles (one cycle to notice, DRAIN cycles of idle).
   logic        m_main_done, m_pim_done, m_stopped, m_prev_both, m_prev_sel;
   logic [63:0] m_mq, m_pq, m_wall;
   int          m_quiet;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_main_done = 1'b0; m_pim_done = 1'b0; m_stopped = 1'b0;
      m_prev_both = 1'b0; m_prev_sel = 1'b0;
      m_mq = 64'd0; m_pq = 64'd0; m_wall = 64'd0; m_quiet = 0;
   endtask

   task automatic cycle();
      logic       rst, both, exp_stop, mex, pex;
      logic [1:0] exp_state;
      int         quiet_now;
      #1;
      rst  = reset | clear;
      both = m_main_done & m_pim_done;
      if (m_stopped)                 exp_state = 2'd3;
      else if (!both || !m_prev_both) exp_state = 2'd0;
      else if (m_prev_sel)           exp_state = 2'd1;
      else                           exp_state = 2'd2;
      quiet_now = (both && !m_stopped && !pim_sel) ? m_quiet + 1 : 0;
      exp_stop  = !rst && (quiet_now == DRAIN + 1);
      chk("main_done", main_done, m_main_done);
      chk("pim_done", pim_done, m_pim_done);
      chk("main_cycles_q", main_cycles_q, m_mq);
      chk("pim_cycles_q", pim_cycles_q, m_pq);
      chk("state_o", state_o, exp_state);
      chk("stop_req", stop_req, exp_stop);
      chk("wall_cycles", wall_cycles, m_wall);
      if (stop_req) begin n_stop++; stop_cyc = cyc_no; end
      if (state_o == 2'd1) n_wait++;
      @(posedge clk);
      if (rst) begin
         model_reset();
      end else begin
         mex = main_fetch_valid && main_rdata == ECALL && main_a7 == EXIT && !m_stopped;
         pex = pim_fetch_valid && pim_rdata == ECALL && pim_a7 == EXIT && !m_stopped;
         if (mex && !m_main_done) begin m_main_done = 1'b1; m_mq = main_cycles; end
         if (pex && !m_pim_done)  begin m_pim_done = 1'b1;  m_pq = pim_cycles;  end
         if (!m_stopped) m_wall = m_wall + 64'd1;
         m_quiet     = quiet_now;
         m_prev_both = both;
         m_prev_sel  = pim_sel;
         if (exp_stop) m_stopped = 1'b1;
      end
      cyc_no++;
      @(negedge clk);
   endtask

   task automatic idle();
      main_fetch_valid = 1'b0;
      pim_fetch_valid  = 1'b0;
   endtask

   task automatic fetch_main(input logic [31:0] rd, input logic [31:0] a7, input logic [63:0] c);
      main_fetch_valid = 1'b1; main_rdata = rd; main_a7 = a7; main_cycles = c;
   endtask

   task automatic fetch_pim(input logic [31:0] rd, input logic [31:0] a7, input logic [63:0] c);
      pim_fetch_valid = 1'b1; pim_rdata = rd; pim_a7 = a7; pim_cycles = c;
   endtask

   task automatic restart();
      clear = 1'b1; idle(); cycle(); clear = 1'b0;
   endtask

   initial begin
      reset = 1'b1; clear = 1'b0; pim_sel = 1'b0;
      main_fetch_valid = 1'b0; main_rdata = 32'd0; main_a7 = 32'd0; main_cycles = 64'd0;
      pim_fetch_valid  = 1'b0; pim_rdata  = 32'd0; pim_a7  = 32'd0; pim_cycles  = 64'd0;
      model_reset();
      @(posedge clk);
      @(negedge clk);
      cycle();
      reset = 1'b0;
      repeat (2) cycle();

      // wrong a7 is not an exit
      fetch_main(ECALL, 32'd10, 64'd42); cycle(); idle(); cycle();
      chk("a7_mismatch_done", main_done, 1'b0);
      chk("a7_mismatch_state", state_o, 2'd0);

      // main exit at 100, PIM exit at 250, bus idle
      fetch_main(ECALL, EXIT, 64'd100); cycle(); idle();
      repeat (4) cycle();
      n_stop = 0;
      main_cycles = 64'd250;
      fetch_pim(ECALL, EXIT, 64'd250);
      e_cyc = cyc_no;
      cycle(); idle();
      repeat (8) cycle();
      chk("basic_main_q", main_cycles_q, 64'd100);
      chk("basic_pim_q", pim_cycles_q, 64'd250);
      chk("basic_state", state_o, 2'd3);
      chk("basic_stop_count", n_stop, 1);
      chk("basic_stop_latency", stop_cyc - (e_cyc + 1), 3);

      // exits after stop are ignored
      fetch_main(ECALL, EXIT, 64'd999); fetch_pim(ECALL, EXIT, 64'd888);
      cycle(); idle(); cycle();
      chk("stopped_pim_q", pim_cycles_q, 64'd250);
      chk("stopped_main_q", main_cycles_q, 64'd100);

      // clear in STOPPED with exits in the same cycle: exits dropped
      clear = 1'b1;
      fetch_main(ECALL, EXIT, 64'd5); fetch_pim(ECALL, EXIT, 64'd6);
      cycle(); clear = 1'b0; idle(); cycle();
      chk("clear_main_done", main_done, 1'b0);
      chk("clear_pim_done", pim_done, 1'b0);
      chk("clear_state", state_o, 2'd0);
      chk("clear_wall", wall_cycles, 64'd1);

      // repeated main exit does not reload the count
      fetch_main(ECALL, EXIT, 64'd7); cycle(); idle();
      repeat (49) cycle();
      fetch_main(ECALL, EXIT, 64'd57); cycle(); idle(); cycle();
      chk("second_exit_q", main_cycles_q, 64'd7);

      // simultaneous exits with pim_sel busy for five WAIT_SEL cycles
      restart();
      n_stop = 0; n_wait = 0;
      pim_sel = 1'b1;
      fetch_main(ECALL, EXIT, 64'd500); fetch_pim(ECALL, EXIT, 64'd600);
      cycle(); idle();
      repeat (5) cycle();
      pim_sel = 1'b0;
      f_cyc = cyc_no;
      repeat (6) cycle();
      chk("sel_wait_cycles", n_wait, 5);
      chk("sel_stop_latency", stop_cyc - f_cyc, 3);
      chk("sel_stop_count", n_stop, 1);
      chk("sel_main_q", main_cycles_q, 64'd500);
      chk("sel_pim_q", pim_cycles_q, 64'd600);

      // pim_sel pulse in second DRAIN cycle restarts the drain
      restart();
      n_stop = 0;
      fetch_main(ECALL, EXIT, 64'd11); fetch_pim(ECALL, EXIT, 64'd22);
      e_cyc = cyc_no;
      cycle(); idle();
      cycle(); cycle();
      pim_sel = 1'b1; cycle(); pim_sel = 1'b0;
      chk("pulse_back_to_wait", state_o, 2'd1);
      repeat (8) cycle();
      chk("pulse_stop_count", n_stop, 1);
      chk("pulse_stop_cycle", stop_cyc - e_cyc, 7);

      // reset mid-drain aborts without a stop pulse
      restart();
      n_stop = 0;
      fetch_main(ECALL, EXIT, 64'd1); fetch_pim(ECALL, EXIT, 64'd2);
      cycle(); idle();
      cycle(); cycle();
      reset = 1'b1; cycle(); reset = 1'b0;
      repeat (6) cycle();
      chk("abort_stop_count", n_stop, 0);
      chk("abort_state", state_o, 2'd0);

      // randomized traffic against the model
      for (int i = 0; i < 600; i++) begin
         main_fetch_valid = ($urandom_range(0, 3) == 0);
         main_rdata       = ($urandom_range(0, 2) == 0) ? ECALL : 32'($urandom);
         main_a7          = ($urandom_range(0, 2) == 0) ? EXIT : 32'($urandom_range(0, 20));
         main_cycles      = {32'($urandom), 32'($urandom)};
         pim_fetch_valid  = ($urandom_range(0, 3) == 0);
         pim_rdata        = ($urandom_range(0, 2) == 0) ? ECALL : 32'($urandom);
         pim_a7           = ($urandom_range(0, 2) == 0) ? EXIT : 32'($urandom_range(0, 20));
         pim_cycles       = {32'($urandom), 32'($urandom)};
         if ($urandom_range(0, 3) == 0) pim_sel = ~pim_sel;
         clear = ($urandom_range(0, 79) == 0);
         reset = ($urandom_range(0, 199) == 0);
         cycle();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/exec_done_monitor.md
EXEC_DONE_MONITOR -- requirements
Module: exec_done_monitor

Interface
REQ-001 Parameter ECALL_WORD, default 32'h00000073, instruction word that signals program exit.
REQ-002 Parameter EXIT_A7, default 32'd1, value of register x17 (a7) that qualifies an exit ECALL.
REQ-003 Parameter DRAIN_CYCLES, default 3, range 1..255, cycles between the all-done condition and the stop request.
REQ-004 clk  in  1  single clock; all state updates on its rising edge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 main_fetch_valid  in  1  main CPU memory read data valid this cycle.
REQ-007 main_rdata  in  32  main CPU memory read data (fetched word).
REQ-008 main_a7  in  32  main CPU register x17.
REQ-009 main_cycles  in  64  main CPU free-running cycle counter.
REQ-010 pim_fetch_valid, pim_rdata, pim_a7, pim_cycles  in  1/32/32/64  same meaning for the PIM core.
REQ-011 pim_sel  in  1  SoC PIM bus-select; 1 means a PIM transaction is in flight.
REQ-012 clear  in  1  synchronous soft clear; returns the block to RUN.
REQ-013 main_done, pim_done  out  1  sticky per-core exit flags.
REQ-014 main_cycles_q, pim_cycles_q  out  64  cycle count captured at each core's exit.
REQ-015 state_o  out  2  current FSM state encoding.
REQ-016 stop_req  out  1  single-cycle pulse requesting end of run.
REQ-017 wall_cycles  out  64  cycles elapsed from reset/clear until stop_req.

Function
REQ-018 Exit detect per core: fetch_valid=1 AND rdata==ECALL_WORD AND a7==EXIT_A7, all evaluated in the same cycle.
REQ-019 On the first main exit detect, main_done SHALL be set and main_cycles_q SHALL load main_cycles, both visible the following cycle.
REQ-020 Later main exit detects SHALL NOT reload main_cycles_q; main_done remains 1 until reset or clear.
REQ-021 REQ-019/020 apply identically and independently to pim_done/pim_cycles_q.
REQ-022 Simultaneous exit detects on both cores in one cycle SHALL set both flags and capture both counts in that cycle.
REQ-023 FSM states: RUN=0, WAIT_SEL=1, DRAIN=2, STOPPED=3.
REQ-024 RUN -> WAIT_SEL when both done flags are 1 (registered values) and pim_sel=1.
REQ-025 RUN -> DRAIN when both done flags are 1 and pim_sel=0; the drain counter loads DRAIN_CYCLES-1.
REQ-026 WAIT_SEL -> DRAIN on the first cycle pim_sel=0; the drain counter loads DRAIN_CYCLES-1.
REQ-027 DRAIN decrements the counter each cycle; at count 0 -> STOPPED with stop_req=1 for exactly that transition cycle.
REQ-028 pim_sel rising to 1 during DRAIN SHALL return to WAIT_SEL; no stop_req is issued.
REQ-029 STOPPED is terminal until reset or clear; stop_req SHALL never pulse twice per run.
REQ-030 wall_cycles increments by 1 each cycle in RUN, WAIT_SEL and DRAIN; it is frozen in STOPPED and saturates at all-ones without wrap.
REQ-031 Exit detects in STOPPED SHALL be ignored.
REQ-032 clear has the same effect as reset; when reset and clear are both asserted, reset behaviour applies.
REQ-033 Exit detects in the cycle that clear is asserted SHALL be discarded.

Reset
REQ-034 On reset: main_done=0, pim_done=0, main_cycles_q=0, pim_cycles_q=0, state_o=RUN, stop_req=0, wall_cycles=0, drain counter=0.
REQ-035 Reset asserted mid-DRAIN SHALL abort the drain with no stop_req pulse.

Verification
REQ-036 Main exit (rdata=0x00000073, a7=1, main_cycles=100), then PIM exit at main_cycles=250 with pim_sel=0 -> main_cycles_q=100, pim_cycles_q=250, stop_req 3 cycles after pim_done rises, state_o=3.
REQ-037 Main rdata=0x00000073 with a7=10 -> main_done stays 0 and no state change.
REQ-038 Both exits in the same cycle with pim_sel=1 held for 5 cycles -> state_o=1 for 5 cycles, then DRAIN, stop_req 3 cycles after pim_sel falls.
REQ-039 Both done, then pim_sel pulses 1 in the 2nd DRAIN cycle -> return to WAIT_SEL, drain restarts, exactly one stop_req per run.
REQ-040 Second main exit 50 cycles after the first -> main_cycles_q unchanged.
REQ-041 clear asserted in STOPPED, then a new exit sequence -> all outputs at reset values, then a fresh run produces one new stop_req and wall_cycles restarts from 0.
